// File: rtl/neuron_seq_ctrl.sv
// rtl/neuron_seq_ctrl.sv - neuron sequencer: saturating MAC over N beats, ReLU, valid/ready result
module neuron_seq_ctrl #(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 8,
    parameter int BIAS_W   = 16,
    parameter int ACC_W    = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    input  logic [BIAS_W-1:0] in_bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_sat,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACC, ACT, OUT} state_t;

    localparam logic [7:0]       LAST_BEAT = 8'(N_INPUTS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                    state;
    state_t                    state_nx;
    logic [ACC_W-1:0]          acc;
    logic [ACC_W-1:0]          res;
    logic [7:0]                cnt;
    logic                      sat;
    logic                      started;
    logic                      accept;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W:0]            prod_ext;
    logic [ACC_W:0]            base_ext;
    logic [ACC_W:0]            sum;
    logic                      ovf;
    logic [ACC_W-1:0]          clamped;

    // One guard bit above the accumulator: overflow shows as the top two sum bits disagreeing.
    assign prod     = $signed(in_x) * $signed(in_w);
    assign prod_ext = {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign base_ext = (state == IDLE) ? {{(ACC_W+1-BIAS_W){in_bias[BIAS_W-1]}}, in_bias}
                                      : {acc[ACC_W-1], acc};
    assign sum      = base_ext + prod_ext;
    assign ovf      = sum[ACC_W] ^ sum[ACC_W-1];
    assign clamped  = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];

    assign accept   = in_valid & in_ready;
    assign busy     = (state != IDLE);

    // Holds in_ready low during reset and until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) started <= 1'b0;
        else        started <= 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and beat acceptance; in_ready is a function of state only.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = started;
                if (accept) state_nx = (N_INPUTS > 1) ? ACC : ACT;
            end
            ACC: begin
                in_ready = started;
                if (accept && (cnt == LAST_BEAT)) state_nx = ACT;
            end
            ACT: state_nx = OUT;
            OUT: if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Accumulate, activate, then load and hold the registered result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            res       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    acc <= clamped;
                    sat <= ovf;
                    cnt <= 8'd1;
                end
                ACC: if (accept) begin
                    acc <= clamped;
                    sat <= sat | ovf;
                    cnt <= cnt + 8'd1;
                end
                ACT: res <= acc[ACC_W-1] ? '0 : acc;
                OUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= res;
                        out_sat   <= sat;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_sat   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// tb/tb_neuron_seq_ctrl.sv - randomized and directed bench for neuron_seq_ctrl with a scoreboard model
module tb_neuron_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_x = '0;
    logic [7:0]  in_w = '0;
    logic [15:0] in_bias = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [16:0] out_data;
    logic        out_sat;
    logic        busy;

    neuron_seq_ctrl #(.N_INPUTS(4), .DATA_W(8), .BIAS_W(16), .ACC_W(17)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_w(in_w), .in_bias(in_bias), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit sat;
        bit lit;
        int ldata;
        bit lsat;
    } exp_t;

    exp_t expq[$];
    int   n_vec = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_cyc = -100;
    int   ready_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: clamp after every add, ReLU at the end, sticky saturation flag.
    task automatic model(input int bias, input int xs[4], input int ws[4],
                         output int res, output bit s);
        int a;
        a = bias;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            a = a + xs[i] * ws[i];
            if (a > 65535)  begin a = 65535;  s = 1; end
            if (a < -65536) begin a = -65536; s = 1; end
        end
        res = (a < 0) ? 0 : a;
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Compare process: every cycle checks output protocol and pops results on handshake.
    bit   pv = 0;
    bit   pt = 0;
    int   pd = 0;
    bit   ps = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pv = 0;
            pt = 0;
        end else begin
            if (out_valid) begin
                chk("in_ready_during_out", 32'(in_ready), 0);
                chk("busy_during_out", 32'(busy), 1);
                if (pv && !pt) begin
                    chk("hold_data", 32'(out_data), pd);
                    chk("hold_sat", 32'(out_sat), 32'(ps));
                end
                if (!pv) chk("latency", cyc - last_cyc, 2);
                if (out_ready) begin
                    if (expq.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_result actual=%0d required=none", out_data);
                    end else begin
                        e = expq.pop_front();
                        chk("result_data", 32'(out_data), e.data);
                        chk("result_sat", 32'(out_sat), 32'(e.sat));
                        if (e.lit) begin
                            chk("literal_data", 32'(out_data), e.ldata);
                            chk("literal_sat", 32'(out_sat), 32'(e.lsat));
                        end
                    end
                end
            end else begin
                chk("idle_out_data", 32'(out_data), 0);
                chk("idle_out_sat", 32'(out_sat), 0);
                if (pt) chk("in_ready_after_take", 32'(in_ready), 1);
            end
            pv = out_valid;
            pt = out_valid && out_ready;
            pd = int'(out_data);
            ps = out_sat;
        end
    end

    // Present one beat and hold it until accepted; called at posedge+1.
    task automatic beat(input int x, input int w, input int b);
        int k;
        in_valid = 1'b1;
        in_x     = 8'(x);
        in_w     = 8'(w);
        in_bias  = 16'(b);
        k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) chk("in_ready_timeout", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input int bias, input int xs[4], input int ws[4], input int gaps[4],
                        input bit lit, input int ld, input bit ls);
        exp_t e;
        model(bias, xs, ws, e.data, e.sat);
        e.lit   = lit;
        e.ldata = ld;
        e.lsat  = ls;
        for (int i = 0; i < 4; i++) begin
            if (gaps[i] > 0) begin
                in_valid = 1'b0;
                in_x     = 8'($urandom);
                in_w     = 8'($urandom);
                repeat (gaps[i]) begin @(posedge clk); #1; end
            end
            beat(xs[i], ws[i], (i == 0) ? bias : int'($urandom_range(0, 65535)));
        end
        last_cyc = cyc;
        expq.push_back(e);
        n_vec++;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((expq.size() != 0 || out_valid) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain", expq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x1[4]    = '{1, 2, 3, 4};
        int w1[4]    = '{1, 1, 1, 1};
        int x5[4]    = '{5, 5, 5, 5};
        int w2[4]    = '{2, 2, 2, 2};
        int xp[4]    = '{127, 127, 127, 127};
        int xn[4]    = '{-128, -128, -128, -128};
        int no_gap[4] = '{0, 0, 0, 0};
        int gap12[4]  = '{0, 0, 3, 0};
        int xr[4];
        int wr[4];
        int gr[4];
        int br;
        int k;

        #2;
        chk("reset_in_ready", 32'(in_ready), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data", 32'(out_data), 0);
        chk("reset_out_sat", 32'(out_sat), 0);
        chk("reset_busy", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_release", 32'(in_ready), 1);

        ready_mode = 0;
        send(10, x1, w1, no_gap, 1, 20, 0);
        send(-100, x5, w2, no_gap, 1, 0, 0);
        send(32767, xp, xp, no_gap, 1, 65535, 1);
        send(10, x1, w1, no_gap, 1, 20, 0);
        send(-32768, xn, xp, no_gap, 1, 0, 1);
        drain();

        ready_mode = 2;
        send(10, x1, w1, gap12, 1, 20, 0);
        k = 0;
        while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
        chk("backpressure_valid", 32'(out_valid), 1);
        repeat (5) begin @(posedge clk); #1; end
        ready_mode = 0;
        drain();

        beat(7, 9, 1000);
        beat(-3, 50, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_out_data", 32'(out_data), 0);
        chk("abort_out_sat", 32'(out_sat), 0);
        chk("abort_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send(10, x1, w1, no_gap, 1, 20, 0);
        drain();

        ready_mode = 1;
        for (int v = 0; v < 40; v++) begin
            if ($urandom_range(0, 3) == 0) begin
                br = ($urandom_range(0, 1) != 0) ? 32767 - int'($urandom_range(0, 2000))
                                                 : -32768 + int'($urandom_range(0, 2000));
                for (int i = 0; i < 4; i++) begin
                    xr[i] = ($urandom_range(0, 1) != 0) ? 127 : -128;
                    wr[i] = ($urandom_range(0, 1) != 0) ? 127 : -128;
                end
            end else begin
                br = int'($urandom_range(0, 65535)) - 32768;
                for (int i = 0; i < 4; i++) begin
                    xr[i] = int'($urandom_range(0, 255)) - 128;
                    wr[i] = int'($urandom_range(0, 255)) - 128;
                end
            end
            for (int i = 0; i < 4; i++) gr[i] = int'($urandom_range(0, 2));
            send(br, xr, wr, gr, 0, 0, 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/neuron_seq_ctrl.md
Name: neuron_seq_ctrl

Overview:
- Sequencer for a single neuron datapath.
- Accepts a stream of N (input, weight) pairs with a per-vector bias over a valid/ready handshake.
- Accumulates bias + Σ x·w into a 17-bit signed saturating accumulator, applies ReLU in a registered activation stage, and presents the result on a valid/ready output.
- Sits between the input/weight feeder and the next layer; it owns all neuron-level sequencing.

Parameters:
- N_INPUTS, 4: number of (x, w) beats per vector; legal range 1..255.
- DATA_W, 8: signed width of x and w.
- BIAS_W, 16: signed width of bias.
- ACC_W, 17: signed width of the accumulator and out_data. Fixed at 17; other values are unsupported.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  x/w/bias beat valid.
- in_ready  out  1  controller accepts a beat this cycle.
- in_x  in  DATA_W  signed input value.
- in_w  in  DATA_W  signed weight.
- in_bias  in  BIAS_W  signed bias; sampled on beat 0 of a vector only.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_W  signed ReLU result, always ≥ 0.
- out_sat  out  1  accumulator saturated at least once during this vector.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous. While rst_n=0:
  - state=IDLE; acc, cnt, res, sat cleared.
  - in_ready=0, out_valid=0, out_data=0, out_sat=0, busy=0.
  - After release, in_ready=1 from the first clock edge onward (IDLE).
- A beat is accepted when in_valid & in_ready at a rising edge.
- States:
  - IDLE: in_ready=1.
    - On an accepted beat: acc ← sat(sext(in_bias) + in_x·in_w); sat ← overflow of that add; cnt ← 1.
    - Next state: ACC if N_INPUTS>1, else ACT.
  - ACC: in_ready=1.
    - On an accepted beat: acc ← sat(acc + in_x·in_w); sat ← sat | overflow; cnt ← cnt+1.
    - When the accepted beat is beat N_INPUTS-1, go to ACT.
    - in_valid low: hold all state indefinitely; no timeout.
  - ACT: in_ready=0. For one cycle, res ← (acc[ACC_W-1] ? 0 : acc). Go to OUT.
  - OUT: in_ready=0, out_valid=1, out_data=res, out_sat=sat.
    - On out_ready=1, go to IDLE.
    - out_data and out_sat hold stable while out_valid=1 & out_ready=0.
- Arithmetic:
  - The product is a full 2·DATA_W signed product, sign-extended to ACC_W+1 before the add.
  - The sum is clamped to [-65536, +65535].
  - overflow = the clamp was applied.
- Latency: last beat accepted at edge T → out_valid=1 after edge T+2. Minimum vector period is N_INPUTS+3 cycles with out_ready tied high.
- Signal timing:
  - out_valid and out_data are registered.
  - in_ready depends only on state; there is no combinational path from out_ready.
  - No new vector is accepted in the same cycle the result is consumed; IDLE's in_ready rises the cycle after the OUT→IDLE handshake.
- out_data=0 outside OUT; out_sat=0 outside OUT.
- Reset mid-vector: the partial accumulation is discarded. The next vector starts clean, with bias sampled again on its beat 0.
- in_bias on beats 1..N-1 is ignored.
- cnt width is 8 bits; it never wraps because N_INPUTS ≤ 255.

Test Plan:
1. N=4, bias=10, x=[1,2,3,4], w=[1,1,1,1], back-to-back beats, out_ready=1 → out_data=20, out_sat=0. out_valid rises exactly 2 cycles after the 4th accept and lasts 1 cycle.
2. bias=-100, x=[5,5,5,5], w=[2,2,2,2] → acc=-60 → out_data=0, out_sat=0.
3. Positive saturation: bias=32767, x=127, w=127 ×4 → true sum 97283, clamped → out_data=65535, out_sat=1. A following vector (test 1 values) returns 20 with out_sat=0.
4. Negative saturation: bias=-32768, x=-128, w=127 ×4 → true sum -97792, clamped to -65536 → out_data=0, out_sat=1.
5. Backpressure and gaps:
   - in_valid low for 3 cycles between beats 1 and 2 → result unchanged (20).
   - out_ready held low for 5 cycles → out_valid, out_data and out_sat stable, in_ready=0.
   - out_ready released → in_ready=1 on the following cycle.
6. Reset mid-vector: assert rst_n=0 asynchronously after 2 beats (mid-cycle) → all outputs 0 immediately. After release, a full test-1 vector yields 20 with no residue from the aborted vector.
